// File: rtl/i2s_transmitter.sv
// I2S serialiser with a one-pair holding buffer; a pair accepted into an empty buffer starts at the next frame load, MSB one bclk later.
// tx_ready drops while a pair is held and returns on the load edge; an empty buffer at load sends a zero frame and pulses underrun.
module i2s_transmitter #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] tx_data_l,
    input  logic [DATA_WIDTH-1:0] tx_data_r,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  sdata,
    output logic                  underrun
);
    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam int BIT_W   = $clog2(2 * SLOT_WIDTH);
    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int PAD_W   = SLOT_WIDTH - DATA_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_M1  = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_M1  = BIT_W'(SLOT_WIDTH - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  buf_full;
    logic [DATA_WIDTH-1:0] buf_l;
    logic [DATA_WIDTH-1:0] buf_r;
    logic [FRAME_W-1:0]    frame_sr;
    logic                  div_wrap;
    logic                  load;
    logic                  accept;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign load     = div_wrap && (bit_cnt == BIT_LAST);
    assign accept   = tx_valid && !buf_full;
    assign tx_ready = !buf_full;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            bclk     <= 1'b0;
            lrck     <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
            frame_sr <= '0;
        end else begin
            div_cnt  <= div_wrap ? '0 : div_cnt + 1'b1;
            underrun <= load && !buf_full;

            if (div_wrap) begin
                bclk <= 1'b0;
            end else if (div_cnt == HALF_M1) begin
                bclk <= 1'b1;
            end

            // lrck/sdata move on the bclk falling edge, which is the div wrap
            if (div_wrap) begin
                bit_cnt <= load ? '0 : bit_cnt + 1'b1;
                lrck    <= !load && (bit_cnt >= SLOT_M1);
                if (load) begin
                    sdata    <= 1'b0;
                    frame_sr <= buf_full ? {buf_l, {PAD_W{1'b0}}, buf_r, {PAD_W{1'b0}}}
                                         : '0;
                end else begin
                    sdata    <= frame_sr[FRAME_W-1];
                    frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
                end
            end

            // The load sees the pre-edge buffer, so a same-edge accept is held for the next frame
            if (accept) begin
                buf_l <= tx_data_l;
                buf_r <= tx_data_r;
            end
            buf_full <= load ? accept : (buf_full || accept);
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Randomised bench for i2s_transmitter: a frame-level reference model plus an I2S receiver decode.
module tb_i2s_transmitter;
    localparam int DW    = 24;
    localparam int S     = 32;
    localparam int DIV   = 4;
    localparam int FRAME = 2 * S * DIV;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data_l = '0;
    logic [DW-1:0] tx_data_r = '0;
    logic          tx_ready, bclk, lrck, sdata, underrun;

    int vectors = 0;
    int errors  = 0;

    i2s_transmitter #(.DATA_WIDTH(DW), .SLOT_WIDTH(S), .BCLK_DIV(DIV)) dut (
        .clk(clk), .resetn(resetn), .tx_data_l(tx_data_l), .tx_data_r(tx_data_r),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .bclk(bclk), .lrck(lrck),
        .sdata(sdata), .underrun(underrun)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n = clk edges since reset release; buffer is a queue of depth <= 1
    int              n = 0;
    logic [2*DW-1:0] q[$];
    logic [DW-1:0]   m_fl = '0;
    logic [DW-1:0]   m_fr = '0;
    logic            m_under = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n = 0;
            q.delete();
            m_fl = '0;
            m_fr = '0;
            m_under = 1'b0;
        end else begin
            logic            acc;
            logic [2*DW-1:0] pr;
            acc = tx_valid && (q.size() == 0);
            n++;
            m_under = 1'b0;
            if (n % FRAME == 0) begin
                if (q.size() > 0) begin
                    pr = q.pop_front();
                    m_fl = pr[2*DW-1:DW];
                    m_fr = pr[DW-1:0];
                end else begin
                    m_fl = '0;
                    m_fr = '0;
                    m_under = 1'b1;
                end
            end
            if (acc) q.push_back({tx_data_l, tx_data_r});
        end
    end

    function automatic logic exp_sdata(input int k);
        if (k >= 1 && k <= DW) return m_fl[DW-k];
        if (k >= S + 1 && k <= S + DW) return m_fr[DW-(k-S)];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        int k;
        k = (n / DIV) % (2 * S);
        chk("bclk", bclk, ((n % DIV) >= DIV / 2));
        chk("lrck", lrck, (k >= S));
        chk("sdata", sdata, exp_sdata(k));
        chk("tx_ready", tx_ready, (q.size() == 0));
        chk("underrun", underrun, m_under);
    end

    // I2S receiver: one bclk delay after each lrck edge, then DW bits MSB first
    int            rx_pos = -1;
    logic          rx_prev = 1'b0;
    logic [DW-1:0] rx_sh = '0, rx_l = '0, rx_last_l = '0, rx_last_r = '0;

    always @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            rx_pos = -1;
            rx_prev = 1'b0;
        end else begin
            if (lrck != rx_prev) rx_pos = 0;
            else rx_pos++;
            rx_prev = lrck;
            if (rx_pos >= 1 && rx_pos <= DW) rx_sh = {rx_sh[DW-2:0], sdata};
            if (rx_pos == DW) begin
                if (!lrck) begin
                    rx_l = rx_sh;
                end else begin
                    rx_last_l = rx_l;
                    rx_last_r = rx_sh;
                    chk("rx_left", rx_l, m_fl);
                    chk("rx_right", rx_sh, m_fr);
                end
            end
        end
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (n != target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (n != target) chk("wait_n", n, target);
    endtask

    initial begin
        int cnt;
        int guard;
        int base;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_bclk", bclk, 0);
        chk("rst_lrck", lrck, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_underrun", underrun, 0);
        resetn = 1'b1;
        wait_n(1);
        chk("bclk_n1", bclk, 0);
        wait_n(2);
        chk("bclk_n2", bclk, 1);

        // Single pair accepted at edge 10, carried by the second frame
        wait_n(9);
        tx_valid = 1'b1;
        tx_data_l = 24'hA5A5A5;
        tx_data_r = 24'h5A5A5A;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("p1_held", tx_ready, 0);
        wait_n(127);
        chk("lrck_n127", lrck, 0);
        wait_n(128);
        chk("lrck_n128", lrck, 1);
        wait_n(255);
        chk("ready_n255", tx_ready, 0);
        wait_n(256);
        chk("ready_n256", tx_ready, 1);
        chk("no_under_n256", underrun, 0);
        wait_n(256 + 4);
        chk("p1_bit23", sdata, 1);
        wait_n(256 + 8);
        chk("p1_bit22", sdata, 0);
        wait_n(256 + 12);
        chk("p1_bit21", sdata, 1);
        wait_n(256 + 4 * (DW + 1));
        chk("p1_pad", sdata, 0);
        wait_n(256 + 4 * (S + 1));
        chk("p1_r_bit23", sdata, 0);
        wait_n(256 + 4 * (S + 2));
        chk("p1_r_bit22", sdata, 1);
        wait_n(488);
        chk("p1_rx_l", rx_last_l, 24'hA5A5A5);
        chk("p1_rx_r", rx_last_r, 24'h5A5A5A);

        // Back-pressure: two distinct pairs with tx_valid held high
        tx_valid = 1'b1;
        tx_data_l = 24'h123456;
        tx_data_r = 24'h654321;
        @(negedge clk);
        tx_data_l = 24'hFEDCBA;
        tx_data_r = 24'h0BCDEF;
        guard = 0;
        while (!tx_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_release_phase", n % FRAME, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("bp_second_held", tx_ready, 0);

        // Three starved frames
        wait_n(769);
        cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (underrun) cnt++;
        end
        chk("underrun_count", cnt, 3);

        // Collision: valid only on the load edge with an empty buffer
        wait_n(1791);
        tx_valid = 1'b1;
        tx_data_l = 24'h13579B;
        tx_data_r = 24'hECA864;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("coll_under", underrun, 1);
        chk("coll_held", tx_ready, 0);
        wait_n(1792 + 232);
        chk("coll_zero_l", rx_last_l, 0);
        chk("coll_zero_r", rx_last_r, 0);
        wait_n(2048 + 232);
        chk("coll_next_l", rx_last_l, 24'h13579B);
        chk("coll_next_r", rx_last_r, 24'hECA864);

        // Random traffic; data changes every cycle whether or not it is accepted
        for (int i = 0; i < 6 * FRAME; i++) begin
            tx_valid = ($urandom_range(0, 5) == 0);
            tx_data_l = DW'($urandom);
            tx_data_r = DW'($urandom);
            @(negedge clk);
        end
        tx_valid = 1'b0;

        // Reset mid-frame with a pair held
        base = ((n / FRAME) + 1) * FRAME;
        wait_n(base);
        tx_valid = 1'b1;
        tx_data_l = 24'h7FFFFF;
        tx_data_r = 24'h800001;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("mid_held", tx_ready, 0);
        wait_n(base + 4 * 40);
        chk("mid_lrck_before", lrck, 1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_bclk", bclk, 0);
        chk("mid_rst_lrck", lrck, 0);
        chk("mid_rst_sdata", sdata, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_underrun", underrun, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_n(256);
        chk("mid_first_load_under", underrun, 1);
        wait_n(488);
        chk("mid_discard_l", rx_last_l, 0);
        chk("mid_discard_r", rx_last_r, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the audio sample width in bits.
REQ-002 The block SHALL have parameter SLOT_WIDTH, default 32, giving the bclk periods per channel slot; legal range DATA_WIDTH+1 or greater.
REQ-003 The block SHALL have parameter BCLK_DIV, default 4, giving the clk cycles per bclk period; legal values are even and 2 or greater.
REQ-004 Port clk, input, width 1: the single clock; all state SHALL change on its rising edge.
REQ-005 Port resetn, input, width 1: asynchronous, active-low reset.
REQ-006 Port tx_data_l, input, width DATA_WIDTH: left sample, two's complement.
REQ-007 Port tx_data_r, input, width DATA_WIDTH: right sample, two's complement.
REQ-008 Port tx_valid, input, width 1: the sample pair on tx_data_l/tx_data_r is valid.
REQ-009 Port tx_ready, output, width 1: the holding buffer can accept a pair.
REQ-010 Port bclk, output, width 1: I2S bit clock.
REQ-011 Port lrck, output, width 1: I2S word select; 0 = left, 1 = right.
REQ-012 Port sdata, output, width 1: I2S serial data, MSB first.
REQ-013 Port underrun, output, width 1: one-clk pulse when a frame starts with the buffer empty.

Function
REQ-014 Divider div_cnt SHALL count 0..BCLK_DIV-1 and wrap; bit counter bit_cnt SHALL count 0..2*SLOT_WIDTH-1, advancing by 1 on each div_cnt wrap to 0, and wrap to 0.
REQ-015 bclk (registered) SHALL become 1 on the edge where div_cnt becomes BCLK_DIV/2, and 0 on the edge where div_cnt becomes 0 (50% duty cycle).
REQ-016 lrck and sdata SHALL update only on the edge where bclk falls, so that they are stable across the bclk rising edge.
REQ-017 lrck SHALL be 0 while bit_cnt is in 0..SLOT_WIDTH-1, and 1 otherwise.
REQ-018 Bit placement: for bit_cnt = k with 1 ≤ k ≤ DATA_WIDTH, sdata SHALL be the left sample bit DATA_WIDTH-k; for k = SLOT_WIDTH+j with 1 ≤ j ≤ DATA_WIDTH, sdata SHALL be the right sample bit DATA_WIDTH-j; all other positions SHALL output 0. This gives the standard I2S one-bclk MSB delay after the lrck edge.
REQ-019 There SHALL be a one-pair holding buffer; tx_ready SHALL be 1 exactly when the buffer is empty.
REQ-020 A pair SHALL be accepted on a clk edge where tx_valid=1 and tx_ready=1; that edge SHALL capture both samples and set the buffer full.
REQ-021 Frame load SHALL occur on the edge where bit_cnt wraps from 2*SLOT_WIDTH-1 to 0.
REQ-022 At a frame load with the buffer full, the buffer contents SHALL move into the frame shift registers and the buffer SHALL become empty.
REQ-023 At a frame load with the buffer empty, the frame SHALL be all zeros and underrun SHALL be 1 for that single clk.
REQ-024 Accept and load on the same edge: the load SHALL see the pre-edge buffer state. If the buffer was empty, the frame SHALL be zeros with underrun, and the new pair SHALL be held for the next frame.
REQ-025 tx_data_l and tx_data_r SHALL be ignored when no accept occurs; a held pair SHALL NOT be overwritten.
REQ-026 Latency: a pair accepted with the buffer empty SHALL begin on sdata (MSB) at the first frame load after acceptance, plus one bclk period.

Reset
REQ-027 While resetn=0: div_cnt=0, bit_cnt=0, bclk=0, lrck=0, sdata=0, underrun=0, tx_ready=1, buffer empty, and the frame registers zero.
REQ-028 After release, the first frame (bit_cnt 0..2*SLOT_WIDTH-1) SHALL transmit zeros without asserting underrun; the first load is the bit_cnt wrap at clk 256 (defaults).
REQ-029 Reset asserted mid-frame SHALL immediately force all REQ-027 values; any held or partially shifted pair SHALL be discarded.

Verification (defaults; frame = 256 clk)
REQ-030 Reset: assert resetn=0 for 3 clk -> bclk=0, lrck=0, sdata=0, tx_ready=1, underrun=0; after release, bclk toggles every 2 clk and lrck toggles every 128 clk.
REQ-031 Single pair: accept L=0xA5A5A5, R=0x5A5A5A at clk 10 -> the second frame carries bits 101001011010010110100101 after the lrck fall, then 8 zeros; the right slot carries 0x5A5A5A; the receiver model decodes the same values.
REQ-032 Back-pressure: hold tx_valid=1 with two distinct pairs -> tx_ready=0 after the first accept until the load edge; the second pair is accepted on the load edge+1 and sent in the following frame, with no loss or duplication.
REQ-033 Underrun: tx_valid=0 for 3 frames after the first frame -> sdata all zeros, with exactly one underrun pulse per frame (3 total).
REQ-034 Collision: tx_valid rises on the load edge with the buffer empty -> underrun=1, that frame is zeros, and the pair is sent in the next frame.
REQ-035 Reset mid-frame: resetn=0 at bit_cnt=40 while a pair is held -> outputs reach REQ-027 values immediately; the pair is never transmitted.
